// File: rtl/fixed_subframe_sequencer_pkg.sv
// Shared types and constants for the FLAC FIXED-subframe sequencer.
package fixed_dec_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int BLOCK_W_DEF     = 16;
  localparam int MAX_FIXED_ORDER = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fixed_subframe_sequencer_if.sv
// Sample stream bundle: upstream warmup/residual input and downstream
// reconstructed-sample output, each with valid/ready flow control.
interface fixed_subframe_sequencer_if
  import fixed_dec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();
  logic signed [DATA_W-1:0] iSample;
  logic                     iValid;
  logic                     oReady;
  logic signed [DATA_W-1:0] oData;
  logic                     oValid;
  logic                     iReady;

  // Producer of samples / consumer of reconstructed data
  modport master (output iSample, output iValid, input oReady,
                  input oData, input oValid, output iReady);
  // The sequencer side
  modport slave  (input iSample, input iValid, output oReady,
                  output oData, output oValid, input iReady);
endinterface

// File: rtl/fixed_subframe_sequencer_out_stage.sv
// Output holding stage: tracks whether the predictor's registered result
// is still waiting for downstream, and tells the sequencer when a new
// sample may be pushed through the predictor without overwriting it.
module fixed_out_stage (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,    // a sample entered the predictor this cycle
  input  logic clr_i,     // drop any pending result
  input  logic ready_i,   // downstream accepts this cycle
  output logic valid_o,
  output logic room_o     // predictor may be advanced this cycle
);
  logic valid_q;

  // Valid flag: clear wins, then load, then downstream drain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign room_o  = !valid_q || ready_i;
endmodule

// File: rtl/fixed_subframe_sequencer.sv
// FLAC FIXED-subframe sequencer: latches order/size on start, clears the
// external predictor, feeds it block-size samples under flow control and
// forwards its registered results downstream.
// Optional macro SUBFRAME_ABORT_EN adds iAbort to cancel a running subframe.
module fixed_subframe_sequencer
  import fixed_dec_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF
) (
  input  logic                     iClock,
  input  logic                     iReset_n,
  input  logic                     iStart,
  input  logic [3:0]               iOrder,
  input  logic [BLOCK_W-1:0]       iBlockSize,
`ifdef SUBFRAME_ABORT_EN
  input  logic                     iAbort,
`endif
  fixed_subframe_sequencer_if.slave bus,
  output logic                     oPredReset,
  output logic                     oPredEnable,
  output logic [3:0]               oPredOrder,
  output logic signed [DATA_W-1:0] oPredSample,
  input  logic signed [DATA_W-1:0] iPredData,
  output logic                     oWarmup,
  output logic                     oBusy,
  output logic                     oDone,
  output logic                     oError
);
  seq_state_t         state_q;
  logic [BLOCK_W-1:0] count_q;
  logic [BLOCK_W-1:0] count_d;
  logic [BLOCK_W-1:0] size_q;
  logic [3:0]         order_q;
  logic               done_q;
  logic               error_q;
  logic               abort;
  logic               accept;
  logic               room;

`ifdef SUBFRAME_ABORT_EN
  assign abort = iAbort && (state_q != IDLE);
`else
  assign abort = 1'b0;
`endif

  assign bus.oReady = (state_q == RUN) && room && (count_q < size_q) && !abort;
  assign accept     = bus.iValid && bus.oReady;
  assign count_d    = count_q + 1'b1;

  fixed_out_stage u_out (
    .clk_i   (iClock),
    .rst_ni  (iReset_n),
    .load_i  (accept),
    .clr_i   (abort),
    .ready_i (bus.iReady),
    .valid_o (bus.oValid),
    .room_o  (room)
  );

  // Control FSM with registered counters and status pulses
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      size_q  <= '0;
      order_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (iStart) begin
              if ((iOrder > 4'(MAX_FIXED_ORDER)) || (iBlockSize == '0)) begin
                error_q <= 1'b1;
              end else begin
                order_q <= iOrder;
                size_q  <= iBlockSize;
                count_q <= '0;
                state_q <= CLEAR;
              end
            end
          end
          CLEAR: state_q <= RUN;
          RUN: begin
            if (accept) begin
              count_q <= count_d;
              if (count_d == size_q) state_q <= FLUSH;
            end
          end
          FLUSH: begin
            if (bus.oValid && bus.iReady) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Predictor reset is held through our own reset so it never sees stale history
  assign oPredReset  = !iReset_n || (state_q == CLEAR) || abort;
  assign oPredEnable = accept;
  assign oPredOrder  = order_q;
  assign oPredSample = bus.iSample;
  assign bus.oData   = iPredData;
  assign oWarmup     = (state_q == RUN) && ({{(BLOCK_W-4){1'b0}}, order_q} > count_q);
  assign oBusy       = (state_q != IDLE);
  assign oDone       = done_q;
  assign oError      = error_q;
endmodule

// File: tb/tb_fixed_subframe_sequencer.sv
// Testbench for fixed_subframe_sequencer: table of subframes with expected
// reconstructed samples, a scoreboard queue, a behavioural fixed predictor
// standing in for the external block, and hand sequences for corner cases.
module tb_fixed_subframe_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [3:0] order;
  logic [15:0] bsize;
  logic abort;
  logic pred_rst, pred_en;
  logic [3:0] pred_order;
  logic signed [15:0] pred_sample;
  logic signed [15:0] pred_out;
  logic warm, busy, done, err;

  fixed_subframe_sequencer_if #(.DATA_W(16)) bus ();

  fixed_subframe_sequencer #(.DATA_W(16), .BLOCK_W(16)) dut (
    .iClock(clk), .iReset_n(rst_n), .iStart(start), .iOrder(order),
    .iBlockSize(bsize),
`ifdef SUBFRAME_ABORT_EN
    .iAbort(abort),
`endif
    .bus(bus.slave),
    .oPredReset(pred_rst), .oPredEnable(pred_en), .oPredOrder(pred_order),
    .oPredSample(pred_sample), .iPredData(pred_out), .oWarmup(warm),
    .oBusy(busy), .oDone(done), .oError(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural fixed predictor (external block): registered output
  logic signed [15:0] h1, h2, h3, h4;
  int p_cnt;
  function automatic int fpred(int o, int a, int b, int c, int d);
    case (o)
      1: return a;
      2: return 2*a - b;
      3: return 3*a - 3*b + c;
      4: return 4*a - 6*b + 4*c - d;
      default: return 0;
    endcase
  endfunction
  always_ff @(posedge clk) begin
    if (pred_rst) begin
      pred_out <= '0; h1 <= '0; h2 <= '0; h3 <= '0; h4 <= '0; p_cnt <= 0;
    end else if (pred_en) begin
      logic signed [15:0] y;
      if (p_cnt < int'(pred_order)) y = pred_sample;
      else y = 16'(fpred(int'(pred_order), h1, h2, h3, h4) + int'(pred_sample));
      pred_out <= y;
      h1 <= y; h2 <= h1; h3 <= h2; h4 <= h3;
      p_cnt <= p_cnt + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream iReady pattern: mode 0 always ready, mode 1 repeats 1,0,0,1
  int ready_mode = 0;
  initial begin
    bus.iReady = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) bus.iReady = 1'b1;
      else bus.iReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
  end

  // Scoreboard checker on the falling edge
  logic signed [15:0] expq[$];
  int last_beat = 0;
  bit prev_stall = 0;
  bit pred_en_seen = 0;
  logic signed [15:0] prev_data;
  always @(negedge clk) begin
    if (pred_en) pred_en_seen = 1;
    if (rst_n) begin
      if (prev_stall) chk("stall_data_stable", bus.oData, prev_data);
      if (bus.oValid && !bus.iReady) chk("stall_pred_enable", pred_en, 0);
      if (bus.oValid && bus.iReady) begin
        last_beat = cyc;
        if (expq.size() == 0) chk("unexpected_output", 1, 0);
        else chk("odata", bus.oData, expq.pop_front());
      end
      prev_stall = bus.oValid && !bus.iReady;
      prev_data  = bus.oData;
    end else begin
      prev_stall = 0;
    end
  end

  typedef struct packed {
    logic [3:0]        order;
    logic [15:0]       size;
    logic              mode;
    logic [7:0][15:0]  s;
    logic [7:0][15:0]  e;
  } vec_t;

  function automatic logic [7:0][15:0] p8(int a0, int a1, int a2, int a3,
                                          int a4, int a5, int a6, int a7);
    logic [7:0][15:0] r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
    r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
    return r;
  endfunction

  task automatic do_start(input int o, input int sz);
    start = 1'b1; order = 4'(o); bsize = 16'(sz);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic signed [15:0] s, input logic signed [15:0] e,
                      input logic w, output int acc_cyc);
    bit got = 0;
    acc_cyc = 0;
    bus.iValid = 1'b1; bus.iSample = s;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.oReady) begin
        got = 1; acc_cyc = cyc;
        chk("warmup", warm, w);
      end
      @(posedge clk); #1;
    end
    if (got) expq.push_back(e);
    else chk("accept_timeout", got, 1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk("done_latency", cyc - last_beat, 1);
        chk("busy_after_done", busy, 0);
        chk("queue_empty", expq.size(), 0);
      end
    end
    chk("done_seen", seen, 1);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int first = 0, last = 0, a = 0;
    ready_mode = int'(v.mode);
    do_start(int'(v.order), int'(v.size));
    chk("clear_pred_reset", pred_rst, 1);
    chk("clear_ready", bus.oReady, 0);
    chk("clear_busy", busy, 1);
    chk("pred_order", pred_order, v.order);
    for (int i = 0; i < int'(v.size); i++) begin
      feed(v.s[i], v.e[i], (i < int'(v.order)), a);
      if (i == 0) first = a;
      last = a;
    end
    bus.iValid = 1'b0;
    if (v.mode == 1'b0) chk("throughput", last - first, int'(v.size) - 1);
    wait_done();
    ready_mode = 0;
  endtask

  vec_t vecs[6];

  initial begin
    int a;
    vecs[0] = '{4'd2, 16'd5, 1'b0, p8(10, 20, 1, 1, 1, 0, 0, 0), p8(10, 20, 31, 43, 56, 0, 0, 0)};
    vecs[1] = '{4'd1, 16'd4, 1'b1, p8(5, 1, 1, 1, 0, 0, 0, 0),   p8(5, 6, 7, 8, 0, 0, 0, 0)};
    vecs[2] = '{4'd0, 16'd1, 1'b0, p8(-7, 0, 0, 0, 0, 0, 0, 0),  p8(-7, 0, 0, 0, 0, 0, 0, 0)};
    vecs[3] = '{4'd3, 16'd5, 1'b1, p8(1, 2, 3, 0, 0, 0, 0, 0),   p8(1, 2, 3, 4, 5, 0, 0, 0)};
    vecs[4] = '{4'd4, 16'd6, 1'b0, p8(1, 4, 9, 16, 0, 0, 0, 0),  p8(1, 4, 9, 16, 25, 36, 0, 0)};
    vecs[5] = '{4'd1, 16'd2, 1'b0, p8(3, 4, 0, 0, 0, 0, 0, 0),   p8(3, 7, 0, 0, 0, 0, 0, 0)};

    rst_n = 1'b0; start = 1'b0; order = '0; bsize = '0; abort = 1'b0;
    bus.iValid = 1'b0; bus.iSample = '0;
    #3;
    chk("rst_valid", bus.oValid, 0);
    chk("rst_done", done, 0);
    chk("rst_error", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pred_reset", pred_rst, 1);
    chk("rst_ready", bus.oReady, 0);
    chk("rst_pred_order", pred_order, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      run_vec(vecs[t]);
      @(posedge clk); #1;
    end

    // Illegal starts: order 5, then size 0
    pred_en_seen = 0;
    do_start(5, 3);
    chk("err_order_pulse", err, 1);
    chk("err_order_busy", busy, 0);
    @(posedge clk); #1;
    chk("err_pulse_width", err, 0);
    do_start(3, 0);
    chk("err_size_pulse", err, 1);
    chk("err_size_busy", busy, 0);
    @(posedge clk); #1;
    chk("err_no_pred_enable", pred_en_seen, 0);

    // Reset dropped mid-run after 3 of 8 samples
    do_start(4, 8);
    feed(7, 7, 1'b1, a);
    feed(8, 8, 1'b1, a);
    feed(9, 9, 1'b1, a);
    bus.iValid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.oValid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pred_reset", pred_rst, 1);
    chk("midrst_pred_order", pred_order, 0);
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[5]);

`ifdef SUBFRAME_ABORT_EN
    // Abort together with an accept in RUN
    do_start(1, 3);
    feed(11, 11, 1'b1, a);
    bus.iValid = 1'b1; bus.iSample = 16'sd2; abort = 1'b1;
    @(negedge clk);
    chk("abort_pred_reset", pred_rst, 1);
    chk("abort_no_accept", pred_en, 0);
    @(posedge clk); #1;
    abort = 1'b0; bus.iValid = 1'b0;
    chk("abort_valid", bus.oValid, 0);
    chk("abort_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fixed_subframe_sequencer.md
Name: fixed_subframe_sequencer

Overview:
Controls one FLAC FIXED-subframe decode through the fixed-order predictor (orders 0-4, 16-bit samples, 1-cycle registered output, sync active-high reset/enable).
- Latches order and block size on a start pulse, clears the predictor, then feeds it exactly block-size samples (warmup then residuals) under valid/ready flow control.
- Forwards reconstructed samples downstream with backpressure and signals completion or error.
- Sits between the residual/warmup reader and the channel output buffer.

Parameters:
DATA_W, 16, sample width; matches predictor.
BLOCK_W, 16, block-size and sample-counter width.

Ports:
iClock  in  1  clock
iReset_n  in  1  asynchronous active-low reset
iStart  in  1  one-cycle start pulse; sampled only in IDLE
iOrder  in  4  fixed order for the subframe, legal 0..4
iBlockSize  in  BLOCK_W  samples in subframe, legal 1..2^BLOCK_W-1
iSample  in  DATA_W  upstream warmup/residual sample
iValid  in  1  upstream sample valid
oReady  out  1  sequencer accepts iSample this cycle
oPredReset  out  1  to predictor reset
oPredEnable  out  1  to predictor enable
oPredOrder  out  4  to predictor order (latched copy)
oPredSample  out  DATA_W  to predictor sample (= iSample)
iPredData  in  DATA_W  predictor output
oData  out  DATA_W  reconstructed sample (= iPredData)
oValid  out  1  oData valid
iReady  in  1  downstream accepts oData
oWarmup  out  1  next accepted sample is warmup (count < order)
oBusy  out  1  state != IDLE
oDone  out  1  one-cycle pulse, last sample consumed downstream
oError  out  1  one-cycle pulse, illegal start rejected

Behaviour:
- Reset (async, iReset_n=0): state IDLE, count 0, order 0, oValid 0, oDone 0, oError 0, oPredReset 1 (combinational in CLEAR or reset), all other outputs 0.
- IDLE: on iStart:
  - If iOrder>4 or iBlockSize==0: pulse oError next cycle, stay IDLE.
  - Otherwise latch order and size, count<=0, go to CLEAR.
  - iStart outside IDLE is ignored.
- CLEAR (1 cycle): oPredReset=1, oReady=0. Then go to RUN.
- RUN:
  - oReady = (!oValid || iReady) && count<size.
  - Accept = iValid && oReady. On accept:
    - oPredEnable=1 that cycle; count++.
    - oValid<=1 next cycle; oData is iPredData, which is the predictor's registered result.
  - If oValid && iReady with no accept, oValid<=0.
  - On the accept that makes count==size, go to FLUSH.
- FLUSH: oReady=0. When oValid && iReady: oValid<=0, oDone pulses next cycle, go to IDLE.
- Latency: iSample accepted at cycle N produces oValid at N+1. Throughput is 1 sample/cycle with iReady held high.
- Stall: while oValid && !iReady, oPredEnable=0, so the predictor holds its state and oData stays stable.
- oWarmup = (state==RUN && count<order).
  - The predictor tracks warmup internally after CLEAR; oWarmup is informational.
- Width: counter BLOCK_W bits, never wraps (bounded by size). No arithmetic on sample data.

Optional Feature:
- Macro SUBFRAME_ABORT_EN.
- When defined, adds input iAbort (1 bit). iAbort=1 in any non-IDLE state:
  - oValid<=0; oPredReset=1 that cycle; go to IDLE next cycle.
  - No oDone pulse; iAbort has priority over accept and completion in the same cycle.
  - iAbort in IDLE is ignored.
- When undefined: no port, no logic; a subframe always runs to completion.

Decomposition:
- Package fixed_dec_pkg:
  - State enum (IDLE, CLEAR, RUN, FLUSH).
  - MAX_FIXED_ORDER=4.
  - DATA_W and BLOCK_W defaults.
- Sub-module fixed_out_stage: the oValid/iReady holding register and stall logic, reusable by the LPC sequencer.
- Predictor instantiated by the parent, not inside this block.

Test Plan:
- Order 2, size 5, samples 10,20,1,1,1, iReady=1 → oData 10,20,31,43,56 on consecutive cycles; oDone 1 cycle after the last beat; oBusy low after.
- Order 1, size 4, samples 5,1,1,1, iReady toggling 1,0,0,1,... → outputs 5,6,7,8 with no loss or duplication; oData stable while iReady=0; oPredEnable never high while stalled.
- iStart with order 5, then order 3 with size 0 → oError pulse each time, oBusy stays 0, no oPredEnable.
- Order 0, size 1, sample -7 → single oData -7; oWarmup 0 throughout; oDone pulse.
- iReset_n dropped mid-RUN after 3 of 8 samples (order 4) → outputs clear immediately; a new start with order 1, size 2, samples 3,4 yields 3,7.
- With SUBFRAME_ABORT_EN: iAbort in RUN together with an accept → no oValid, no oDone, oPredReset asserted, IDLE next cycle.
